// File: rtl/sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// sseg_scan_driver
// Time-multiplexed seven-segment driver for NUM_DIGITS hex digits.
// One digit is lit at a time. Each digit slot is 16 PWM steps of PRESCALE
// clocks. A digit is on while step < brightness, so step 15 is always dark.
// That dark step is the guard band that stops ghosting between digits.
// data/dp/blank/brightness are captured once per frame, so the display never
// tears.
//
// Optional feature (macro SSEG_LZB_EN): leading-zero blanking, applied when
// the snapshot is taken. Digits are scanned from the top down, and each digit
// with nibble 0 and dp 0 is blanked until the first non-zero nibble or set dp.
// Digit 0 is never auto-blanked.
//
// Ports:
//   clock        system clock, rising edge
//   reset_n      asynchronous active-low reset
//   data         hex nibbles, digit i = data[4i+3:4i], digit 0 rightmost
//   dp           decimal point request per digit (1 = lit)
//   blank        force digit dark (1 = blank)
//   brightness   PWM level 0..15 (0 = dark)
//   sseg         segments {G,F,E,D,C,B,A}, active-low, registered
//   dp_n         decimal point segment, active-low, registered
//   anodes       digit enables, active-low, registered
//   frame_start  one-cycle pulse after each input snapshot
// -----------------------------------------------------------------------------
module sseg_scan_driver #(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE   = 1024
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [4*NUM_DIGITS-1:0] data,
    input  logic [NUM_DIGITS-1:0]   dp,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [3:0]              brightness,
    output logic [6:0]              sseg,
    output logic                    dp_n,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic                    frame_start
);

    localparam int PS_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

    // Hex to active-high gfedcba pattern.
    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            4'hF:    seg = 7'h71;
            default: seg = 7'h00;
        endcase
        return seg;
    endfunction

`ifdef SSEG_LZB_EN
    // Mask of leading digits to blank. Once a non-blankable digit is seen,
    // no digit below it is blanked. Digit 0 is never part of the mask.
    function automatic logic [NUM_DIGITS-1:0] lzb_mask(
        input logic [4*NUM_DIGITS-1:0] nibs,
        input logic [NUM_DIGITS-1:0]   dps
    );
        logic                  leading;
        logic [NUM_DIGITS-1:0] m;
        leading = 1'b1;
        m       = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            if (leading && (nibs[4*i +: 4] == 4'h0) && !dps[i]) begin
                m[i] = 1'b1;
            end else begin
                leading = 1'b0;
            end
        end
        return m;
    endfunction
`endif

    // Scan state
    logic [PS_W-1:0]         ps_q,   ps_d;
    logic [3:0]              step_q, step_d;
    logic [IDX_W-1:0]        idx_q,  idx_d;
    // Set in reset, so the first edge after release takes a snapshot.
    logic                    init_q;
    // Snapshot
    logic [4*NUM_DIGITS-1:0] snap_data_q;
    logic [NUM_DIGITS-1:0]   snap_dp_q;
    logic [NUM_DIGITS-1:0]   snap_blank_q;
    logic [3:0]              snap_bright_q;
    // Registered outputs
    logic [6:0]              sseg_q,   sseg_d;
    logic                    dp_n_q,   dp_n_d;
    logic [NUM_DIGITS-1:0]   anodes_q, anodes_d;
    logic                    frame_start_q;

    logic                    tick_s;
    logic                    frame_wrap_s;
    logic                    snap_take_s;
    logic [NUM_DIGITS-1:0]   blank_eff_s;
    logic [3:0]              cur_nib_s;
    logic                    cur_dp_s;
    logic                    cur_blank_s;
    logic                    digit_on_s;

    // Prescaler, step and digit index next-state logic
    always_comb begin
        tick_s       = (ps_q == PS_LAST);
        frame_wrap_s = tick_s && (step_q == 4'd15) && (idx_q == IDX_LAST);
        snap_take_s  = init_q || frame_wrap_s;
        if (tick_s) begin
            ps_d   = '0;
            step_d = step_q + 4'd1;
        end else begin
            ps_d   = ps_q + PS_W'(1);
            step_d = step_q;
        end
        if (tick_s && (step_q == 4'd15)) begin
            if (idx_q == IDX_LAST) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end else begin
            idx_d = idx_q;
        end
    end

    // Effective blanking captured with the snapshot
    always_comb begin
`ifdef SSEG_LZB_EN
        blank_eff_s = blank | lzb_mask(data, dp);
`else
        blank_eff_s = blank;
`endif
    end

    // Select the current digit's snapshot fields and form the outputs
    always_comb begin
        cur_nib_s   = 4'h0;
        cur_dp_s    = 1'b0;
        cur_blank_s = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib_s   = snap_data_q[4*i +: 4];
                cur_dp_s    = snap_dp_q[i];
                cur_blank_s = snap_blank_q[i];
            end else begin
                cur_nib_s   = cur_nib_s;
            end
        end
        digit_on_s = (step_q < snap_bright_q) && !cur_blank_s;
        anodes_d   = '1;
        if (digit_on_s) begin
            sseg_d = ~hex_decode(cur_nib_s);
            dp_n_d = ~cur_dp_s;
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (idx_q == IDX_W'(i)) begin
                    anodes_d[i] = 1'b0;
                end else begin
                    anodes_d[i] = 1'b1;
                end
            end
        end else begin
            sseg_d = 7'h7F;
            dp_n_d = 1'b1;
        end
    end

    // Scan counters and snapshot registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ps_q          <= '0;
            step_q        <= 4'd0;
            idx_q         <= '0;
            init_q        <= 1'b1;
            snap_data_q   <= '0;
            snap_dp_q     <= '0;
            snap_blank_q  <= '0;
            snap_bright_q <= 4'd0;
        end else begin
            ps_q   <= ps_d;
            step_q <= step_d;
            idx_q  <= idx_d;
            init_q <= 1'b0;
            if (snap_take_s) begin
                snap_data_q   <= data;
                snap_dp_q     <= dp;
                snap_blank_q  <= blank_eff_s;
                snap_bright_q <= brightness;
            end else begin
                snap_data_q   <= snap_data_q;
            end
        end
    end

    // Output registers. anodes and sseg update together, so there is no skew.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sseg_q        <= 7'h7F;
            dp_n_q        <= 1'b1;
            anodes_q      <= '1;
            frame_start_q <= 1'b0;
        end else begin
            sseg_q        <= sseg_d;
            dp_n_q        <= dp_n_d;
            anodes_q      <= anodes_d;
            frame_start_q <= snap_take_s;
        end
    end

    assign sseg        = sseg_q;
    assign dp_n        = dp_n_q;
    assign anodes      = anodes_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// -----------------------------------------------------------------------------
// Testbench for sseg_scan_driver (NUM_DIGITS=4, PRESCALE=2).
// A reference model computes each expected output cycle from the elapsed cycle
// count since reset release. The model derives:
//   - step  = (count / PRESCALE) % 16
//   - digit = (count / slot) % NUM_DIGITS
// It also keeps its own copy of the frame snapshot.
// -----------------------------------------------------------------------------
module tb_sseg_scan_driver;

    localparam int ND    = 4;
    localparam int PS    = 2;
    localparam int FRAME = 16 * PS * ND;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic [15:0]   data = 16'h0000;
    logic [3:0]    dp = 4'h0;
    logic [3:0]    blank = 4'h0;
    logic [3:0]    brightness = 4'h0;
    logic [6:0]    sseg;
    logic          dp_n;
    logic [3:0]    anodes;
    logic          frame_start;

    int vecs  = 0;
    int fails = 0;
    int c     = 0;      // clock edges since reset release
    int lit_cnt = 0;

    // Model snapshot
    logic [3:0] m_nib [ND];
    logic [3:0] m_dp;
    logic [3:0] m_blank;
    logic [3:0] m_br;
    logic [6:0] seg_tab [16];

    sseg_scan_driver #(.NUM_DIGITS(ND), .PRESCALE(PS)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .data        (data),
        .dp          (dp),
        .blank       (blank),
        .brightness  (brightness),
        .sseg        (sseg),
        .dp_n        (dp_n),
        .anodes      (anodes),
        .frame_start (frame_start)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, c);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < ND; i++) m_nib[i] = 4'h0;
        m_dp = 4'h0; m_blank = 4'h0; m_br = 4'h0;
    endtask

    task automatic model_snap();
        int top;
        for (int i = 0; i < ND; i++) m_nib[i] = data[4*i +: 4];
        m_dp = dp;
        m_br = brightness;
        m_blank = blank;
`ifdef SSEG_LZB_EN
        // Highest digit that must stay visible. Everything above it is blanked.
        top = 0;
        for (int i = 0; i < ND; i++)
            if (data[4*i +: 4] != 4'h0 || dp[i]) top = i;
        for (int i = top + 1; i < ND; i++) m_blank[i] = 1'b1;
`else
        top = 0;
`endif
    endtask

    task automatic check_dark(input string tag);
        chk({tag, "_sseg"}, 16'(sseg), 16'h007F);
        chk({tag, "_dpn"}, 16'(dp_n), 16'h0001);
        chk({tag, "_anodes"}, 16'(anodes), 16'h000F);
        chk({tag, "_fs"}, 16'(frame_start), 16'h0000);
    endtask

    // One clock: predict the outputs registered at this edge, update the model, check.
    task automatic step_cycle();
        int s, st, ix;
        logic on;
        logic [6:0] e_sseg;
        logic e_dpn, e_fs;
        logic [3:0] e_an;
        @(posedge clock);
        c = c + 1;
        s  = c - 1;
        st = (s / PS) % 16;
        ix = (s / (16 * PS)) % ND;
        on = (st < int'(m_br)) && !m_blank[ix];
        e_an = 4'hF; e_sseg = 7'h7F; e_dpn = 1'b1;
        if (on) begin
            e_an[ix] = 1'b0;
            e_sseg   = ~seg_tab[m_nib[ix]];
            e_dpn    = ~m_dp[ix];
        end
        e_fs = (c == 1) || (c % FRAME == 0);
        if (e_fs) model_snap();
        #1;
        if (anodes != 4'hF) lit_cnt++;
        chk("sseg", 16'(sseg), 16'(e_sseg));
        chk("dp_n", 16'(dp_n), 16'(e_dpn));
        chk("anodes", 16'(anodes), 16'(e_an));
        chk("frame_start", 16'(frame_start), 16'(e_fs));
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) step_cycle();
    endtask

    task automatic rand_inputs();
        data = 16'($urandom()); dp = 4'($urandom()); blank = 4'($urandom());
        brightness = 4'($urandom());
    endtask

    initial begin
        seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
        model_clear();

        // Reset held with random inputs
        for (int k = 0; k < 5; k++) begin
            rand_inputs();
            @(posedge clock); #1;
            check_dark("reset");
        end

        // Scan order with brightness 15, no blanking
        data = 16'($urandom()); dp = 4'h0; blank = 4'h0; brightness = 4'd15;
        @(negedge clock);
        reset_n = 1'b1;
        c = 0;
        run(FRAME - 1);

        // Decode and dp
        data = 16'h12AF; dp = 4'b0100;
        run(FRAME);

        // brightness 0: fully dark
        brightness = 4'd0; dp = 4'h0;
        lit_cnt = 0;
        run(FRAME);
        chk("br0_lit", 16'(lit_cnt), 16'd0);

        // brightness 8: half duty
        brightness = 4'd8;
        lit_cnt = 0;
        run(FRAME);
        chk("br8_lit", 16'(lit_cnt), 16'(ND * 8 * PS));

        // Snapshot holds across mid-frame input changes
        data = 16'h1234; brightness = 4'd15;
        run(40);
        data = 16'h5678; brightness = 4'd3;
        run(FRAME - 40);
        run(FRAME);

        // Leading zeros (blanked only with SSEG_LZB_EN)
        data = 16'h0070; dp = 4'h0; blank = 4'h0; brightness = 4'd15;
        run(FRAME);
        data = 16'h0000; dp = 4'h0;
        run(FRAME);
        data = 16'h0305; dp = 4'b0000; blank = 4'b0101;
        run(FRAME);

        // Random frames with random mid-frame changes
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < FRAME; k++) begin
                if ($urandom_range(0, 15) == 0) rand_inputs();
                step_cycle();
            end
        end

        // Asynchronous reset mid-scan, then fresh restart
        brightness = 4'd15; blank = 4'h0; data = 16'($urandom());
        run(50);
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_dark("async_rst");
        model_clear();
        for (int k = 0; k < 3; k++) begin
            @(posedge clock); #1;
            check_dark("rst_hold");
        end
        data = 16'hC0DE; dp = 4'b1001;
        @(negedge clock);
        reset_n = 1'b1;
        c = 0;
        run(FRAME + 20);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
